// File: rtl/keypad_code_lock_if.sv
// Keypad-to-lock connection: scanner key codes in, lock status and feedback out.
// The master drives key codes; the lock controller is the slave.
interface keypad_code_lock_if;
   logic [3:0] key_in;
   logic       unlocked;
   logic       lockout;
   logic       ok_pulse;
   logic       fail_pulse;
   logic [2:0] digit_count;
   logic [2:0] state_out;

   modport master (
      output key_in,
      input  unlocked, lockout, ok_pulse, fail_pulse, digit_count, state_out
   );

   modport slave (
      input  key_in,
      output unlocked, lockout, ok_pulse, fail_pulse, digit_count, state_out
   );
endinterface

// File: rtl/keypad_code_lock.sv
// Passcode controller: collects keypad digits, checks them against a volatile
// stored code, and drives unlock, lockout and one-cycle feedback pulses.
module keypad_code_lock #(
   parameter int                      CODE_LEN       = 4,
   parameter int                      MAX_FAIL       = 3,
   parameter int                      UNLOCK_CYCLES  = 512,
   parameter int                      LOCKOUT_CYCLES = 1024,
   parameter logic [4*CODE_LEN-1:0]   DEFAULT_CODE   = 16'h1234
) (
   input  logic                 clk,
   input  logic                 rst,
   keypad_code_lock_if.slave    bus
);

   localparam int          W       = 4 * CODE_LEN;
   localparam logic [2:0]  LEN3    = 3'(CODE_LEN);
   localparam logic [3:0]  MAXF4   = 4'(MAX_FAIL);
   localparam logic [15:0] T_OPEN  = 16'(UNLOCK_CYCLES - 1);
   localparam logic [15:0] T_LOCK  = 16'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ENTRY   = 3'd1,
      CHECK   = 3'd2,
      OPEN    = 3'd3,
      PROG    = 3'd4,
      LOCKOUT = 3'd5
   } state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  buf_q, buf_d;
   logic [W-1:0]  code_q, code_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [3:0]    fail_q, fail_d;
   logic [15:0]   timer_q, timer_d;
   logic          ok_q, ok_d;
   logic          flp_q, flp_d;
   logic          unlocked_q, lockout_q;

   logic          is_digit, is_hash, is_star;
   logic          full, match, expired;
   logic [W-1:0]  app_buf;
   logic [2:0]    app_cnt;
   logic          app_ovf;
   logic [3:0]    fail_inc;
   logic [15:0]   timer_dec;

   assign is_digit  = (bus.key_in <= 4'd9);
   assign is_hash   = (bus.key_in == 4'd10);
   assign is_star   = (bus.key_in == 4'd11);
   assign full      = (cnt_q == LEN3);
   assign match     = full && !ovf_q && (buf_q == code_q);
   assign expired   = (timer_q == 16'd0);
   assign fail_inc  = fail_q + 4'd1;
   assign timer_dec = expired ? 16'd0 : timer_q - 16'd1;

   // A digit into a full buffer only flags overflow; the buffer content is kept.
   always_comb begin
      app_buf = buf_q;
      app_cnt = cnt_q;
      app_ovf = ovf_q;
      if (full) begin
         app_ovf = 1'b1;
      end else begin
         app_buf      = buf_q << 4;
         app_buf[3:0] = bus.key_in;
         app_cnt      = cnt_q + 3'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      fail_d  = fail_q;
      code_d  = code_q;
      timer_d = timer_q;
      ok_d    = 1'b0;
      flp_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (is_digit) begin
               buf_d   = W'(bus.key_in);
               cnt_d   = 3'd1;
               ovf_d   = 1'b0;
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            if (is_digit) begin
               buf_d = app_buf;
               cnt_d = app_cnt;
               ovf_d = app_ovf;
            end else if (is_star) begin
               buf_d   = '0;
               cnt_d   = 3'd0;
               ovf_d   = 1'b0;
               state_d = IDLE;
            end else if (is_hash) begin
               state_d = CHECK;
            end
         end
         CHECK: begin
            buf_d = '0;
            cnt_d = 3'd0;
            ovf_d = 1'b0;
            if (match) begin
               state_d = OPEN;
               fail_d  = 4'd0;
               ok_d    = 1'b1;
               timer_d = T_OPEN;
            end else begin
               flp_d = 1'b1;
               if (fail_inc == MAXF4) begin
                  state_d = LOCKOUT;
                  fail_d  = 4'd0;
                  timer_d = T_LOCK;
               end else begin
                  state_d = IDLE;
                  fail_d  = fail_inc;
               end
            end
         end
         OPEN: begin
            timer_d = timer_dec;
            if (expired || is_star) begin
               state_d = IDLE;
            end else if (is_hash) begin
               buf_d   = '0;
               cnt_d   = 3'd0;
               ovf_d   = 1'b0;
               state_d = PROG;
            end
         end
         PROG: begin
            timer_d = timer_dec;
            if (expired) begin
               buf_d   = '0;
               cnt_d   = 3'd0;
               ovf_d   = 1'b0;
               state_d = IDLE;
            end else if (is_digit) begin
               buf_d = app_buf;
               cnt_d = app_cnt;
               ovf_d = app_ovf;
            end else if (is_hash || is_star) begin
               if (is_hash && full && !ovf_q) begin
                  code_d = buf_q;
                  ok_d   = 1'b1;
               end else if (is_hash) begin
                  flp_d  = 1'b1;
               end
               buf_d   = '0;
               cnt_d   = 3'd0;
               ovf_d   = 1'b0;
               timer_d = T_OPEN;
               state_d = OPEN;
            end
         end
         LOCKOUT: begin
            timer_d = timer_dec;
            if (expired) state_d = IDLE;
         end
         default: begin
            buf_d   = '0;
            cnt_d   = 3'd0;
            ovf_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         buf_q      <= '0;
         code_q     <= DEFAULT_CODE;
         cnt_q      <= 3'd0;
         ovf_q      <= 1'b0;
         fail_q     <= 4'd0;
         timer_q    <= 16'd0;
         ok_q       <= 1'b0;
         flp_q      <= 1'b0;
         unlocked_q <= 1'b0;
         lockout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         code_q     <= code_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         fail_q     <= fail_d;
         timer_q    <= timer_d;
         ok_q       <= ok_d;
         flp_q      <= flp_d;
         unlocked_q <= (state_d == OPEN) || (state_d == PROG);
         lockout_q  <= (state_d == LOCKOUT);
      end
   end

   assign bus.unlocked    = unlocked_q;
   assign bus.lockout     = lockout_q;
   assign bus.ok_pulse    = ok_q;
   assign bus.fail_pulse  = flp_q;
   assign bus.digit_count = cnt_q;
   assign bus.state_out   = state_q;

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: directed scenarios then random key bursts, all
// checked every cycle against a deadline/queue-based behavioural model.
module tb_keypad_code_lock;

   localparam int          L    = 4;
   localparam int          MAXF = 3;
   localparam int          UC   = 512;
   localparam int          LC   = 1024;
   localparam logic [15:0] DEF  = 16'h1234;

   logic clk;
   logic rst;
   keypad_code_lock_if kif();

   keypad_code_lock #(
      .CODE_LEN(L), .MAX_FAIL(MAXF), .UNLOCK_CYCLES(UC),
      .LOCKOUT_CYCLES(LC), .DEFAULT_CODE(DEF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (kif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: state number, typed digits as a queue, absolute expiry edge.
   int m_state;
   int m_entry[$];
   bit m_ovf;
   int m_fails;
   int m_code[L];
   int m_deadline;
   int cyc = 0;
   bit m_ok, m_flp;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit entry_matches();
      if (m_entry.size() != L || m_ovf) return 1'b0;
      for (int i = 0; i < L; i++) if (m_entry[i] != m_code[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void clear_entry();
      m_entry.delete();
      m_ovf = 1'b0;
   endfunction

   function automatic void push_digit(input int k);
      if (m_entry.size() == L) m_ovf = 1'b1;
      else m_entry.push_back(k);
   endfunction

   task automatic model_edge(input int k, input bit r);
      bit dg, hs, st;
      cyc++;
      m_ok  = 1'b0;
      m_flp = 1'b0;
      if (!r) begin
         m_state = 0;
         clear_entry();
         m_fails = 0;
         for (int i = 0; i < L; i++) m_code[i] = int'((DEF >> (4*(L-1-i))) & 16'hF);
         return;
      end
      dg = (k >= 0 && k <= 9);
      hs = (k == 10);
      st = (k == 11);
      case (m_state)
         0: if (dg) begin clear_entry(); m_entry.push_back(k); m_state = 1; end
         1: begin
            if (dg) push_digit(k);
            else if (st) begin clear_entry(); m_state = 0; end
            else if (hs) m_state = 2;
         end
         2: begin
            if (entry_matches()) begin
               m_state = 3; m_fails = 0; m_ok = 1'b1; m_deadline = cyc + UC;
            end else begin
               m_fails++; m_flp = 1'b1;
               if (m_fails == MAXF) begin
                  m_state = 5; m_fails = 0; m_deadline = cyc + LC;
               end else m_state = 0;
            end
            clear_entry();
         end
         3: begin
            if (cyc == m_deadline || st) m_state = 0;
            else if (hs) begin clear_entry(); m_state = 4; end
         end
         4: begin
            if (cyc == m_deadline) begin clear_entry(); m_state = 0; end
            else if (dg) push_digit(k);
            else if (hs || st) begin
               if (hs && m_entry.size() == L && !m_ovf) begin
                  for (int i = 0; i < L; i++) m_code[i] = m_entry[i];
                  m_ok = 1'b1;
               end else if (hs) m_flp = 1'b1;
               clear_entry();
               m_state = 3;
               m_deadline = cyc + UC;
            end
         end
         5: if (cyc == m_deadline) m_state = 0;
         default: m_state = 0;
      endcase
   endtask

   task automatic check_all();
      chk("state_out",   16'(kif.state_out),   16'(m_state));
      chk("unlocked",    16'(kif.unlocked),    16'(m_state == 3 || m_state == 4));
      chk("lockout",     16'(kif.lockout),     16'(m_state == 5));
      chk("ok_pulse",    16'(kif.ok_pulse),    16'(m_ok));
      chk("fail_pulse",  16'(kif.fail_pulse),  16'(m_flp));
      chk("digit_count", 16'(kif.digit_count), 16'(m_entry.size()));
   endtask

   task automatic step(input int k, input bit r = 1'b1);
      kif.key_in = 4'(k);
      rst = r;
      @(posedge clk);
      model_edge(k, r);
      #1;
      check_all();
   endtask

   task automatic press(input int k);
      step(k);
      step(13);
   endtask

   task automatic enter(input int d[$]);
      foreach (d[i]) press(d[i]);
      press(10);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) step(12 + int'($urandom_range(0, 3)));
   endtask

   int cnt;
   int q[$];

   initial begin
      kif.key_in = 4'd13;
      rst = 1'b0;
      step(13, 1'b0);
      step(13, 1'b0);
      chk("reset_state", 16'(kif.state_out), 16'd0);
      chk("reset_dc",    16'(kif.digit_count), 16'd0);

      // Unlock and exact open duration.
      press(1); press(2); press(3); press(4); step(10);
      chk("check_state", 16'(kif.state_out), 16'd2);
      step(13);
      chk("open_ok", 16'(kif.ok_pulse), 16'd1);
      cnt = 0;
      for (int i = 0; i < 700 && kif.unlocked; i++) begin cnt++; step(13); end
      chk("unlock_len", 16'(cnt), 16'(UC));
      chk("relock_idle", 16'(kif.state_out), 16'd0);

      // Three wrong codes, lockout ignores a correct code, then unlock.
      enter('{1, 2, 3, 5});
      enter('{1, 2, 3, 5});
      press(1); press(2); press(3); press(5); step(10); step(13);
      chk("lockout_on", 16'(kif.lockout), 16'd1);
      q = '{1, 13, 2, 13, 3, 13, 4, 13, 10};
      cnt = 0;
      for (int i = 0; i < 1200 && kif.lockout; i++) begin
         cnt++;
         step(i < q.size() ? q[i] : 13);
      end
      chk("lockout_len", 16'(cnt), 16'(LC));
      enter('{1, 2, 3, 4});
      chk("post_lock_unlock", 16'(kif.unlocked), 16'd1);
      step(11);
      chk("star_relock", 16'(kif.unlocked), 16'd0);

      // Length errors and star abort.
      enter('{1, 2, 3});
      press(1); press(2); press(3); press(4); press(5);
      chk("ovf_saturate", 16'(kif.digit_count), 16'd4);
      press(10);
      press(1); press(2); step(11);
      chk("star_clear", 16'(kif.digit_count), 16'd0);

      // Reprogram to 9876, verify, then reset restores the default.
      enter('{1, 2, 3, 4});
      press(10); press(9); press(8); press(7); press(6); step(10);
      chk("prog_ok", 16'(kif.ok_pulse), 16'd1);
      step(11);
      enter('{1, 2, 3, 4});
      enter('{9, 8, 7, 6});
      chk("new_code_open", 16'(kif.unlocked), 16'd1);
      step(13, 1'b0);
      enter('{1, 2, 3, 4});
      chk("default_restored", 16'(kif.unlocked), 16'd1);

      // Hash on the expiry cycle is dropped.
      for (int i = 0; i < 700 && (m_deadline - cyc) > 1; i++) step(13);
      step(10);
      chk("expiry_wins", 16'(kif.state_out), 16'd0);

      // Reset in the middle of lockout.
      repeat (3) enter('{0, 0, 0, 0});
      repeat (5) step(13);
      step(13, 1'b0);
      chk("rst_lockout", 16'(kif.lockout), 16'd0);

      // Random bursts.
      for (int b = 0; b < 150; b++) begin
         case ($urandom_range(0, 11))
            0, 1, 2: begin
               foreach (m_code[i]) begin step(m_code[i]); gap(); end
               step(10); gap();
            end
            3: begin
               repeat ($urandom_range(1, 6)) begin step(int'($urandom_range(0, 9))); gap(); end
               step(10); gap();
            end
            4: begin
               repeat ($urandom_range(0, 5)) begin step(int'($urandom_range(0, 9))); gap(); end
               step(11); gap();
            end
            5, 6: begin
               step(10); gap();
               repeat ($urandom_range(3, 5)) begin step(int'($urandom_range(0, 9))); gap(); end
               step($urandom_range(0, 3) == 0 ? 11 : 10); gap();
            end
            7: step(11);
            8: repeat ($urandom_range(0, 50)) step(13);
            9: repeat ($urandom_range(400, 600)) step(int'($urandom_range(12, 15)));
            10: if ($urandom_range(0, 3) == 0) step(13, 1'b0);
            default: repeat (10) step(int'($urandom_range(0, 15)));
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
